pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. It watches the instruction in ID and the load in EX, and inserts one-cycle load-use stalls. It flushes the wrong-path instructions after a taken branch or jump, and drains the pipeline and freezes it when a HALT opcode reaches ID. It drives the PC, IF/ID and ID/EX write, bubble and flush controls.

## Interface
Parameters:
- FLUSH_CYCLES, 2: cycles of IF/ID and ID/EX flush after a taken branch resolves in EX.
- DRAIN_CYCLES, 3: cycles the pipeline runs after HALT before freezing (EX, MEM, WB drain).
- HALT_OPCODE, 6'b111111: opcode (instr[31:26]) treated as HALT.

Ports:
- clock, input, 1: single clock.
- reset, input, 1: asynchronous, active-high.
- id_instr, input, 32: instruction currently in ID.
- id_uses_rt, input, 1: the ID instruction reads rt (R-type, beq/bne, sw).
- ex_memRead, input, 1: the instruction in EX is a load.
- ex_rt, input, 5: destination register of the load in EX (ID/EX regAddr2).
- ex_branch_taken, input, 1: branch/jump in EX resolved taken this cycle.
- pc_write, output, 1: PC register load enable.
- ifid_write, output, 1: IF/ID register load enable.
- idex_bubble, output, 1: ID/EX loads its reset-value control fields instead of decoded ones.
- ifid_flush, output, 1: IF/ID loads a NOP (32'b0).
- halted, output, 1: the pipeline is frozen.
- stall_count, output, 16: count of cycles with load-use stalls, saturating.

## Operation
- States: RUN, FLUSH, DRAIN, HALTED.
- Load-use hazard (combinational): ex_memRead && ex_rt!=0 && (ex_rt==id_instr[25:21] || (id_uses_rt && ex_rt==id_instr[20:16])).
- Priority in RUN: ex_branch_taken > load-use > HALT.
- RUN, taken branch: ifid_flush=1, idex_bubble=1, pc_write=1. Go to FLUSH with the counter at FLUSH_CYCLES-1. If FLUSH_CYCLES==1, stay in RUN.
- RUN, load-use: pc_write=0, ifid_write=0, idex_bubble=1. Stay in RUN. stall_count increments, saturating at 16'hFFFF.
- RUN, HALT in ID with no hazard: pc_write=0, ifid_write=0, idex_bubble=1. Go to DRAIN with the counter at DRAIN_CYCLES-1.
- RUN, no event: pc_write=1, ifid_write=1, all other outputs 0.
- FLUSH: ifid_flush=1, idex_bubble=1, pc_write=1. The counter decrements and the block returns to RUN at 0. Load-use and HALT are ignored, because the ID instruction is wrong-path. A new ex_branch_taken reloads the counter.
- DRAIN: pc_write=0, ifid_write=0, idex_bubble=1. The counter decrements and the block goes to HALTED at 0.
- HALTED: halted=1, pc_write=0, ifid_write=0, idex_bubble=1. Only reset leaves this state.
- A taken branch arriving during DRAIN is impossible, because HALT is younger; it is ignored.
- A HALT on the wrong path is flushed before it acts, since FLUSH masks it.

## Timing
- Reset values: state=RUN, counter=0, stall_count=0, halted=0. The combinational outputs then read pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
- Reset asserted mid-FLUSH or mid-DRAIN returns to RUN immediately (asynchronous).
- pc_write, ifid_write, idex_bubble and ifid_flush are combinational from state and inputs, with zero-cycle latency into the current-cycle register loads.
- State, counter, stall_count and halted are registered on posedge clock.
- Load-use costs exactly 1 stall cycle. The next cycle sees ex_memRead=0, because of the bubble.
- A taken branch costs FLUSH_CYCLES flushed cycles, counting the detection cycle.
- halted rises DRAIN_CYCLES+1 cycles after HALT is first seen in ID.

## Configuration
- PIPE_STEP_EN: when defined, adds ports step_en (input, 1) and step (input, 1, one-cycle pulse).
- With step_en=1, the state/counter update and pc_write/ifid_write occur only in cycles where step=1. Otherwise pc_write=0 and ifid_write=0, the state holds, and idex_bubble is forced to 0, with ID/EX held by the existing enable. stall_count counts only stepped cycles.
- Without the macro, the ports are absent and the block behaves as step_en=0.

## Structure
- Shared package pipe_pkg: the state encoding (RUN=2'd0, FLUSH=2'd1, DRAIN=2'd2, HALTED=2'd3), HALT_OPCODE, NOP_INSTR=32'b0.
- Sub-module hazard_detect (combinational): the load-use compare and the HALT opcode decode.
- The FSM, counter and stall_count stay in pipeline_ctrl.

## Test plan
- lw $2 in EX (ex_rt=2), add with rs=2 in ID: one cycle of pc_write=0/ifid_write=0/idex_bubble=1, then RUN. stall_count=1.
- Same load, but the ID instruction has rt=2 and id_uses_rt=0: no stall. With ex_rt=0: no stall.
- ex_branch_taken for one cycle, FLUSH_CYCLES=2: ifid_flush=1 on two consecutive cycles. A load-use hazard in the second cycle is ignored.
- ex_branch_taken and load-use in the same cycle: flush wins, and stall_count is unchanged.
- HALT in ID: pc_write=0 from that cycle, and halted=1 exactly 4 cycles later with DRAIN_CYCLES=3. Further inputs have no effect. Reset pulsed in the middle of DRAIN returns to RUN with halted=0.
- PIPE_STEP_EN, step_en=1, HALT in ID: the state advances only on step pulses, so halted rises after 4 step pulses regardless of the idle cycles in between.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// FSM state encoding, HALT opcode, NOP instruction and counter width.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_e;

    localparam logic [5:0]  HALT_OPCODE = 6'b111111;
    localparam logic [31:0] NOP_INSTR   = 32'b0;

    // Wide enough for any realistic FLUSH_CYCLES / DRAIN_CYCLES setting.
    localparam int CNT_W = 8;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the MIPS datapath and pipeline_ctrl: hazard inputs from
// ID/EX and the register-enable controls back to the datapath.
interface pipeline_ctrl_if;

    logic [31:0] id_instr;
    logic        id_uses_rt;
    logic        ex_memRead;
    logic [4:0]  ex_rt;
    logic        ex_branch_taken;

    logic        pc_write;
    logic        ifid_write;
    logic        idex_bubble;
    logic        ifid_flush;
    logic        halted;
    logic [15:0] stall_count;

    modport master (
        output id_instr, id_uses_rt, ex_memRead, ex_rt, ex_branch_taken,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, halted, stall_count
    );

    modport slave (
        input  id_instr, id_uses_rt, ex_memRead, ex_rt, ex_branch_taken,
        output pc_write, ifid_write, idex_bubble, ifid_flush, halted, stall_count
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use compare between the ID instruction and the load
// in EX, plus HALT opcode decode of the ID instruction.
module hazard_detect #(
    parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
    input  logic [31:0] id_instr,
    input  logic        id_uses_rt,
    input  logic        ex_memRead,
    input  logic [4:0]  ex_rt,
    output logic        load_use,
    output logic        is_halt
);

    logic [4:0] id_rs;
    logic [4:0] id_rt;

    assign id_rs = id_instr[25:21];
    assign id_rt = id_instr[20:16];

    // $0 is hard-wired zero, so a load "into" it never creates a dependency.
    assign load_use = ex_memRead && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    assign is_halt = (id_instr[31:26] == HALT_OPCODE);

    // Immediate/rd/funct bits play no part in hazard or HALT detection.
    logic unused_instr_bits;
    assign unused_instr_bits = ^id_instr[15:0];

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use
// stalls, branch flushes, HALT drain/freeze. Optional single-step port pair
// enabled by defining PIPE_STEP_EN.
module pipeline_ctrl #(
    parameter int         FLUSH_CYCLES = 2,
    parameter int         DRAIN_CYCLES = 3,
    parameter logic [5:0] HALT_OPCODE  = pipe_pkg::HALT_OPCODE
) (
    input  logic                  clock,
    input  logic                  reset,
`ifdef PIPE_STEP_EN
    input  logic                  step_en,
    input  logic                  step,
`endif
    pipeline_ctrl_if.slave        bus
);

    import pipe_pkg::*;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        stall_q, stall_d;
    logic               halted_q, halted_d;

    logic               load_use;
    logic               is_halt;
    logic               advance;

    hazard_detect #(
        .HALT_OPCODE (HALT_OPCODE)
    ) u_hazard (
        .id_instr   (bus.id_instr),
        .id_uses_rt (bus.id_uses_rt),
        .ex_memRead (bus.ex_memRead),
        .ex_rt      (bus.ex_rt),
        .load_use   (load_use),
        .is_halt    (is_halt)
    );

`ifdef PIPE_STEP_EN
    assign advance = !step_en || step;
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        state_d         = state_q;
        cnt_d           = cnt_q;
        stall_d         = stall_q;
        bus.pc_write    = 1'b1;
        bus.ifid_write  = 1'b1;
        bus.idex_bubble = 1'b0;
        bus.ifid_flush  = 1'b0;

        unique case (state_q)
            RUN: begin
                if (bus.ex_branch_taken) begin
                    bus.ifid_flush  = 1'b1;
                    bus.idex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    end
                end else if (load_use) begin
                    bus.pc_write    = 1'b0;
                    bus.ifid_write  = 1'b0;
                    bus.idex_bubble = 1'b1;
                    if (stall_q != 16'hFFFF) begin
                        stall_d = stall_q + 16'd1;
                    end
                end else if (is_halt) begin
                    bus.pc_write    = 1'b0;
                    bus.ifid_write  = 1'b0;
                    bus.idex_bubble = 1'b1;
                    state_d         = DRAIN;
                    cnt_d           = CNT_W'(DRAIN_CYCLES - 1);
                end
            end

            // The detection cycle already counted as one flush cycle, so the
            // last FLUSH cycle is the one entered with the counter at 1.
            FLUSH: begin
                bus.ifid_flush  = 1'b1;
                bus.idex_bubble = 1'b1;
                if (bus.ex_branch_taken) begin
                    cnt_d = CNT_W'(FLUSH_CYCLES - 1);
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            DRAIN: begin
                bus.pc_write    = 1'b0;
                bus.ifid_write  = 1'b0;
                bus.idex_bubble = 1'b1;
                if (cnt_q == '0) begin
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            HALTED: begin
                bus.pc_write    = 1'b0;
                bus.ifid_write  = 1'b0;
                bus.idex_bubble = 1'b1;
            end

            default: ;
        endcase

        // Between step pulses the whole pipeline holds still.
        if (!advance) begin
            state_d         = state_q;
            cnt_d           = cnt_q;
            stall_d         = stall_q;
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.idex_bubble = 1'b0;
            bus.ifid_flush  = 1'b0;
        end

        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            stall_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stall_q  <= stall_d;
            halted_q <= halted_d;
        end
    end

    assign bus.halted      = halted_q;
    assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, hand-written
// reset/step sequences, and randomized stimulus against a behavioural model.
module tb_pipeline_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int DRAIN_CYCLES = 3;

    localparam logic [31:0] I_NONE   = 32'h0000_0000;
    localparam logic [31:0] I_ADD_R2 = 32'h0043_2020;  // add $4,$2,$3  (rs=2)
    localparam logic [31:0] I_RT2    = 32'h00A2_2020;  // add $4,$5,$2  (rt=2)
    localparam logic [31:0] I_RS0    = 32'h0003_2020;  // add $4,$0,$3  (rs=0)
    localparam logic [31:0] I_HALT   = 32'hFC00_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
`ifdef PIPE_STEP_EN
    logic step_en = 1'b0;
    logic step    = 1'b0;
`endif

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clock   (clock),
        .reset   (reset),
`ifdef PIPE_STEP_EN
        .step_en (step_en),
        .step    (step),
`endif
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Tracks how many flush / drain cycles remain, not an FSM encoding.
    int  m_flush_left;
    int  m_drain_left;
    bit  m_halted;
    int  m_stall;
    bit  e_pc, e_ifid, e_bub, e_fl, e_halted;
    int  e_stall;

    function automatic bit ref_load_use(logic [31:0] instr, bit uses_rt, bit mr, logic [4:0] rt);
        int rs_f = (instr >> 21) & 31;
        int rt_f = (instr >> 16) & 31;
        return mr && rt != 0 && (int'(rt) == rs_f || (uses_rt && int'(rt) == rt_f));
    endfunction

    task automatic model_reset();
        m_flush_left = 0;
        m_drain_left = 0;
        m_halted     = 0;
        m_stall      = 0;
    endtask

    // Produces this cycle's expected outputs, then advances to post-edge state.
    task automatic model_cycle(input logic [31:0] instr, input bit uses_rt, input bit mr,
                               input logic [4:0] rt, input bit br, input bit adv);
        bit lu   = ref_load_use(instr, uses_rt, mr, rt);
        bit halt = (instr >> 26) == 63;
        e_halted = m_halted;
        e_stall  = m_stall;
        e_pc = 1; e_ifid = 1; e_bub = 0; e_fl = 0;
        if (m_halted) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
        end else if (m_drain_left > 0) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
            if (adv) begin
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1;
            end
        end else if (m_flush_left > 0) begin
            e_fl = 1; e_bub = 1;
            if (adv) m_flush_left = br ? FLUSH_CYCLES - 1 : m_flush_left - 1;
        end else if (br) begin
            e_fl = 1; e_bub = 1;
            if (adv) m_flush_left = FLUSH_CYCLES - 1;
        end else if (lu) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
            if (adv && m_stall < 65535) m_stall++;
        end else if (halt) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
            if (adv) m_drain_left = DRAIN_CYCLES;
        end
        if (!adv) begin
            e_pc = 0; e_ifid = 0; e_bub = 0; e_fl = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [31:0] instr, input bit uses_rt, input bit mr,
                         input logic [4:0] rt, input bit br);
        @(negedge clock);
        bus.id_instr        = instr;
        bus.id_uses_rt      = uses_rt;
        bus.ex_memRead      = mr;
        bus.ex_rt           = rt;
        bus.ex_branch_taken = br;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        drive(I_NONE, 0, 0, 5'd0, 0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_cycle(input string tag, input logic [31:0] instr, input bit uses_rt,
                             input bit mr, input logic [4:0] rt, input bit br, input bit adv);
        drive(instr, uses_rt, mr, rt, br);
        model_cycle(instr, uses_rt, mr, rt, br, adv);
        check({tag, "_pc_write"},    bus.pc_write,    e_pc);
        check({tag, "_ifid_write"},  bus.ifid_write,  e_ifid);
        check({tag, "_idex_bubble"}, bus.idex_bubble, e_bub);
        check({tag, "_ifid_flush"},  bus.ifid_flush,  e_fl);
        check({tag, "_halted"},      bus.halted,      e_halted);
        check({tag, "_stall_count"}, bus.stall_count, e_stall);
    endtask

    typedef struct {
        logic [31:0] instr;
        bit          uses_rt;
        bit          mr;
        logic [4:0]  rt;
        bit          br;
        bit          pc;
        bit          ifid;
        bit          bub;
        bit          fl;
        bit          halted;
        logic [15:0] stall;
        string       name;
    } vec_t;

    vec_t vecs[18];

    initial begin
        //            instr     urt mr rt    br   pc if bub fl  h  stall
        vecs[0]  = '{I_NONE,   0, 0, 5'd0, 0,   1, 1, 0, 0, 0, 16'd0, "reset_idle"};
        vecs[1]  = '{I_ADD_R2, 0, 1, 5'd2, 0,   0, 0, 1, 0, 0, 16'd0, "lu_rs"};
        vecs[2]  = '{I_ADD_R2, 0, 0, 5'd2, 0,   1, 1, 0, 0, 0, 16'd1, "lu_release"};
        vecs[3]  = '{I_RT2,    0, 1, 5'd2, 0,   1, 1, 0, 0, 0, 16'd1, "rt_not_used"};
        vecs[4]  = '{I_RT2,    1, 1, 5'd2, 0,   0, 0, 1, 0, 0, 16'd1, "lu_rt_used"};
        vecs[5]  = '{I_RS0,    1, 1, 5'd0, 0,   1, 1, 0, 0, 0, 16'd2, "ex_rt_zero"};
        vecs[6]  = '{I_NONE,   0, 0, 5'd0, 1,   1, 1, 1, 1, 0, 16'd2, "br_detect"};
        vecs[7]  = '{I_ADD_R2, 0, 1, 5'd2, 0,   1, 1, 1, 1, 0, 16'd2, "flush_masks_lu"};
        vecs[8]  = '{I_NONE,   0, 0, 5'd0, 0,   1, 1, 0, 0, 0, 16'd2, "flush_done"};
        vecs[9]  = '{I_ADD_R2, 0, 1, 5'd2, 1,   1, 1, 1, 1, 0, 16'd2, "br_beats_lu"};
        vecs[10] = '{I_HALT,   0, 0, 5'd0, 0,   1, 1, 1, 1, 0, 16'd2, "flush_masks_halt"};
        vecs[11] = '{I_NONE,   0, 0, 5'd0, 0,   1, 1, 0, 0, 0, 16'd2, "no_stall_count"};
        vecs[12] = '{I_HALT,   0, 0, 5'd0, 0,   0, 0, 1, 0, 0, 16'd2, "halt_detect"};
        vecs[13] = '{I_ADD_R2, 1, 1, 5'd2, 1,   0, 0, 1, 0, 0, 16'd2, "drain_1"};
        vecs[14] = '{I_ADD_R2, 1, 1, 5'd2, 1,   0, 0, 1, 0, 0, 16'd2, "drain_2"};
        vecs[15] = '{I_ADD_R2, 1, 1, 5'd2, 1,   0, 0, 1, 0, 0, 16'd2, "drain_3"};
        vecs[16] = '{I_ADD_R2, 1, 1, 5'd2, 1,   0, 0, 1, 0, 1, 16'd2, "halted_rise"};
        vecs[17] = '{I_NONE,   0, 0, 5'd0, 1,   0, 0, 1, 0, 1, 16'd2, "halted_hold"};

        bus.id_instr = I_NONE; bus.id_uses_rt = 0; bus.ex_memRead = 0;
        bus.ex_rt = 5'd0; bus.ex_branch_taken = 0;

        // ---- directed vector table ----
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].instr, vecs[i].uses_rt, vecs[i].mr, vecs[i].rt, vecs[i].br);
            check({vecs[i].name, "_pc_write"},    bus.pc_write,    vecs[i].pc);
            check({vecs[i].name, "_ifid_write"},  bus.ifid_write,  vecs[i].ifid);
            check({vecs[i].name, "_idex_bubble"}, bus.idex_bubble, vecs[i].bub);
            check({vecs[i].name, "_ifid_flush"},  bus.ifid_flush,  vecs[i].fl);
            check({vecs[i].name, "_halted"},      bus.halted,      vecs[i].halted);
            check({vecs[i].name, "_stall_count"}, bus.stall_count, vecs[i].stall);
        end

        // ---- back-to-back branches reload the flush window ----
        do_reset();
        run_cycle("reload_a", I_NONE, 0, 0, 5'd0, 1, 1);
        run_cycle("reload_b", I_NONE, 0, 0, 5'd0, 1, 1);
        run_cycle("reload_c", I_ADD_R2, 0, 1, 5'd2, 0, 1);
        run_cycle("reload_d", I_NONE, 0, 0, 5'd0, 0, 1);

        // ---- asynchronous reset in the middle of DRAIN ----
        do_reset();
        run_cycle("mid_drain_halt", I_HALT, 0, 0, 5'd0, 0, 1);
        run_cycle("mid_drain_1", I_NONE, 0, 0, 5'd0, 0, 1);
        @(negedge clock);
        bus.id_instr = I_NONE;
        #2 reset = 1'b1;
        #1;
        check("async_reset_pc_write",    bus.pc_write,    1);
        check("async_reset_idex_bubble", bus.idex_bubble, 0);
        check("async_reset_halted",      bus.halted,      0);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) run_cycle("post_reset", I_NONE, 0, 0, 5'd0, 0, 1);

`ifdef PIPE_STEP_EN
        // ---- single-step: HALT advances only on step pulses ----
        do_reset();
        step_en = 1'b1;
        for (int p = 0; p < 4; p++) begin
            step = 1'b0;
            run_cycle("step_idle", I_HALT, 0, 0, 5'd0, 0, 0);
            run_cycle("step_idle", I_HALT, 0, 0, 5'd0, 0, 0);
            check("step_not_halted", bus.halted, 0);
            step = 1'b1;
            run_cycle("step_pulse", I_HALT, 0, 0, 5'd0, 0, 1);
        end
        step = 1'b0;
        run_cycle("step_after4", I_NONE, 0, 0, 5'd0, 0, 0);
        check("step_halted_after_4", bus.halted, 1);
        step_en = 1'b0;
`endif

        // ---- randomized stimulus against the model ----
        do_reset();
        begin
            int halted_run = 0;
            for (int n = 0; n < 1500; n++) begin
                logic [31:0] instr;
                bit          adv = 1;
                logic [5:0]  opc = ($urandom_range(0, 40) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
                instr = {opc, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
`ifdef PIPE_STEP_EN
                step_en = 1'($urandom_range(0, 3) == 0);
                step    = 1'($urandom_range(0, 1));
                adv     = !step_en || step;
`endif
                run_cycle("rnd", instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0), adv);
                halted_run = m_halted ? halted_run + 1 : 0;
                if (halted_run > 3 || $urandom_range(0, 199) == 0) begin
                    halted_run = 0;
                    do_reset();
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
